// File: rtl/dmem_if_if.sv
// Data-bus bundle between the memory-stage interface (master) and the data memory (slave).
// One request channel (valid/ready) and one response strobe channel.
interface dmem_if_if;
  logic        d_req_valid;
  logic        d_req_ready;
  logic        d_req_we;
  logic [31:0] d_req_addr;
  logic [3:0]  d_req_wstrb;
  logic [31:0] d_req_wdata;
  logic        d_rsp_valid;
  logic [31:0] d_rsp_rdata;
  logic        d_rsp_err;

  modport master (
    output d_req_valid, d_req_we, d_req_addr, d_req_wstrb, d_req_wdata,
    input  d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err
  );

  modport slave (
    input  d_req_valid, d_req_we, d_req_addr, d_req_wstrb, d_req_wdata,
    output d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err
  );
endinterface

// File: rtl/dmem_if.sv
// Memory-stage data-memory interface: one load/store per instruction on a valid/ready bus,
// aligned and extended load data to write-back, pipeline stall while a transaction is open.
module dmem_if #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        mem_valid,
  input  logic        mem_load,
  input  logic        mem_store,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_result,
  input  logic [4:0]  mem_rd_idx_in,
  input  logic        mem_rd_en_in,
  dmem_if_if.master   bus,
  output logic        mem_stall,
  output logic        wb_valid,
  output logic        wb_rd_en,
  output logic [4:0]  wb_rd_idx,
  output logic [31:0] wb_rd_data,
  output logic        misalign_trap,
  output logic        bus_err,
  output logic [31:0] fault_addr
);

  typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_e;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e      state, state_d;
  logic [7:0]  cnt, cnt_d;
  logic        accept;

  logic [31:0] lat_addr;
  logic [2:0]  lat_funct3;
  logic        lat_we;
  logic [3:0]  lat_wstrb;
  logic [31:0] lat_wdata;
  logic [4:0]  lat_rd_idx;
  logic        lat_rd_en;

  logic        wb_valid_d, wb_rd_en_d, misalign_d, bus_err_d;
  logic [4:0]  wb_rd_idx_d;
  logic [31:0] wb_rd_data_d, fault_addr_d;

  logic        is_access, misaligned, timeout_hit;
  logic [3:0]  strb;
  logic [31:0] wdata_rep, rsp_shifted, load_data;

  assign is_access   = mem_valid & (mem_load | mem_store);
  assign misaligned  = (mem_funct3[1:0] == 2'b11) ||
                       (mem_funct3[1:0] == 2'b01 && mem_addr[0]) ||
                       (mem_funct3[1:0] == 2'b10 && mem_addr[1:0] != 2'b00);
  // Saturating compare: a handshake on the last REQ cycle lands in RSP already past the limit.
  assign timeout_hit = (cnt >= TO_LAST);

  // NOTE: every always_comb output gets a default first, so no path leaves a latch behind.
  always_comb begin
    strb      = 4'b1111;
    wdata_rep = mem_wdata;
    case (mem_funct3[1:0])
      2'b00: begin
        strb      = 4'b0001 << mem_addr[1:0];
        wdata_rep = {4{mem_wdata[7:0]}};
      end
      2'b01: begin
        strb      = 4'b0011 << mem_addr[1:0];
        wdata_rep = {2{mem_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign rsp_shifted = bus.d_rsp_rdata >> {lat_addr[1:0], 3'b000};

  always_comb begin
    case (lat_funct3)
      3'b000:  load_data = {{24{rsp_shifted[7]}}, rsp_shifted[7:0]};
      3'b001:  load_data = {{16{rsp_shifted[15]}}, rsp_shifted[15:0]};
      3'b100:  load_data = {24'd0, rsp_shifted[7:0]};
      3'b101:  load_data = {16'd0, rsp_shifted[15:0]};
      default: load_data = rsp_shifted;
    endcase
  end

  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    accept       = 1'b0;
    wb_valid_d   = 1'b0;
    wb_rd_en_d   = 1'b0;
    misalign_d   = 1'b0;
    bus_err_d    = 1'b0;
    wb_rd_idx_d  = wb_rd_idx;
    wb_rd_data_d = wb_rd_data;
    fault_addr_d = fault_addr;
    case (state)
      IDLE: begin
        if (!is_access) begin
          wb_valid_d   = mem_valid;
          wb_rd_en_d   = mem_valid & mem_rd_en_in;
          wb_rd_idx_d  = mem_rd_idx_in;
          wb_rd_data_d = mem_result;
        end else if (misaligned) begin
          wb_valid_d   = 1'b1;
          misalign_d   = 1'b1;
          wb_rd_idx_d  = mem_rd_idx_in;
          fault_addr_d = mem_addr;
        end else begin
          accept  = 1'b1;
          cnt_d   = 8'd0;
          state_d = REQ;
        end
      end
      REQ, RSP: begin
        cnt_d = cnt + 8'd1;
        if (state == REQ && bus.d_req_ready) begin
          state_d = RSP;
        end else if (state == RSP && bus.d_rsp_valid) begin
          state_d     = DONE;
          wb_valid_d  = 1'b1;
          wb_rd_idx_d = lat_rd_idx;
          if (bus.d_rsp_err) begin
            bus_err_d    = 1'b1;
            fault_addr_d = lat_addr;
          end else if (!lat_we) begin
            wb_rd_en_d   = lat_rd_en;
            wb_rd_data_d = load_data;
          end
        end else if (timeout_hit) begin
          state_d      = DONE;
          wb_valid_d   = 1'b1;
          wb_rd_idx_d  = lat_rd_idx;
          bus_err_d    = 1'b1;
          fault_addr_d = lat_addr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rstn) begin
      state         <= IDLE;
      cnt           <= 8'd0;
      lat_addr      <= '0;
      lat_funct3    <= '0;
      lat_we        <= 1'b0;
      lat_wstrb     <= '0;
      lat_wdata     <= '0;
      lat_rd_idx    <= '0;
      lat_rd_en     <= 1'b0;
      wb_valid      <= 1'b0;
      wb_rd_en      <= 1'b0;
      wb_rd_idx     <= '0;
      wb_rd_data    <= '0;
      misalign_trap <= 1'b0;
      bus_err       <= 1'b0;
      fault_addr    <= '0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      wb_valid      <= wb_valid_d;
      wb_rd_en      <= wb_rd_en_d;
      wb_rd_idx     <= wb_rd_idx_d;
      wb_rd_data    <= wb_rd_data_d;
      misalign_trap <= misalign_d;
      bus_err       <= bus_err_d;
      fault_addr    <= fault_addr_d;
      if (accept) begin
        lat_addr   <= mem_addr;
        lat_funct3 <= mem_funct3;
        lat_we     <= mem_store;
        lat_wstrb  <= mem_store ? strb : 4'b0000;
        lat_wdata  <= wdata_rep;
        lat_rd_idx <= mem_rd_idx_in;
        lat_rd_en  <= mem_rd_en_in;
      end
    end
  end

  assign bus.d_req_valid = (state == REQ);
  assign bus.d_req_we    = lat_we;
  assign bus.d_req_addr  = {lat_addr[31:2], 2'b00};
  assign bus.d_req_wstrb = lat_wstrb;
  assign bus.d_req_wdata = lat_wdata;

  assign mem_stall = (state == IDLE && is_access && !misaligned) ||
                     (state == REQ) || (state == RSP);

endmodule

// File: tb/tb_dmem_if.sv
// Directed bench for dmem_if: one instance at the default timeout, one with TIMEOUT=4
// for the abort, error-response and response-at-limit cases.
module tb_dmem_if;
  logic        clk = 1'b0;
  logic        rstn;
  logic        mv_a, mv_b, mem_load, mem_store, rd_en;
  logic [2:0]  f3;
  logic [31:0] addr, wdata, result;
  logic [4:0]  rd;

  logic        stall_a, wbv_a, wbe_a, mis_a, err_a;
  logic [4:0]  idx_a;
  logic [31:0] data_a, fa_a;
  logic        stall_b, wbv_b, wbe_b, mis_b, err_b;
  logic [4:0]  idx_b;
  logic [31:0] data_b, fa_b;

  int n_vec = 0;
  int n_bad = 0;
  int stalls;

  dmem_if_if bus_a ();
  dmem_if_if bus_b ();

  always #5 clk = ~clk;

  dmem_if dut (
    .clk(clk), .rstn(rstn), .mem_valid(mv_a), .mem_load(mem_load), .mem_store(mem_store),
    .mem_funct3(f3), .mem_addr(addr), .mem_wdata(wdata), .mem_result(result),
    .mem_rd_idx_in(rd), .mem_rd_en_in(rd_en), .bus(bus_a.master), .mem_stall(stall_a),
    .wb_valid(wbv_a), .wb_rd_en(wbe_a), .wb_rd_idx(idx_a), .wb_rd_data(data_a),
    .misalign_trap(mis_a), .bus_err(err_a), .fault_addr(fa_a)
  );

  dmem_if #(.TIMEOUT(4)) dut_to (
    .clk(clk), .rstn(rstn), .mem_valid(mv_b), .mem_load(mem_load), .mem_store(mem_store),
    .mem_funct3(f3), .mem_addr(addr), .mem_wdata(wdata), .mem_result(result),
    .mem_rd_idx_in(rd), .mem_rd_en_in(rd_en), .bus(bus_b.master), .mem_stall(stall_b),
    .wb_valid(wbv_b), .wb_rd_en(wbe_b), .wb_rd_idx(idx_b), .wb_rd_data(data_b),
    .misalign_trap(mis_b), .bus_err(err_b), .fault_addr(fa_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mv_a = 1'b0; mv_b = 1'b0; mem_load = 1'b0; mem_store = 1'b0;
    f3 = 3'b000; addr = '0; wdata = '0; result = '0; rd = '0; rd_en = 1'b0;
  endtask

  task automatic drive_access(input logic st, input logic [2:0] fn, input logic [31:0] a,
                              input logic [31:0] wd, input logic [4:0] r);
    mem_load = !st; mem_store = st; f3 = fn; addr = a; wdata = wd; rd = r; rd_en = 1'b1;
  endtask

  // Minimum-latency transaction on the default-timeout instance: accept T0, REQ T1, RSP T2, DONE T3.
  task automatic run_min(input string tag, input logic st, input logic [2:0] fn,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdata,
                         input logic [3:0] exp_strb, input logic [31:0] exp_wd,
                         input logic [31:0] exp_rd, input logic exp_en);
    mv_a = 1'b1;
    drive_access(st, fn, a, wd, 5'd9);
    bus_a.d_req_ready = 1'b1;
    #1;
    check({tag, " stall_t0"}, stall_a, 1);
    check({tag, " req_valid_t0"}, bus_a.d_req_valid, 0);
    tick();
    check({tag, " req_valid_t1"}, bus_a.d_req_valid, 1);
    check({tag, " req_addr"}, bus_a.d_req_addr, {a[31:2], 2'b00});
    check({tag, " req_wstrb"}, bus_a.d_req_wstrb, exp_strb);
    check({tag, " req_wdata"}, bus_a.d_req_wdata, exp_wd);
    check({tag, " req_we"}, bus_a.d_req_we, st);
    check({tag, " stall_t1"}, stall_a, 1);
    tick();
    bus_a.d_req_ready = 1'b0;
    bus_a.d_rsp_valid = 1'b1;
    bus_a.d_rsp_rdata = rdata;
    #1;
    check({tag, " stall_t2"}, stall_a, 1);
    check({tag, " req_valid_t2"}, bus_a.d_req_valid, 0);
    tick();
    bus_a.d_rsp_valid = 1'b0;
    idle_inputs();
    #1;
    check({tag, " wb_valid_t3"}, wbv_a, 1);
    check({tag, " wb_rd_en_t3"}, wbe_a, exp_en);
    check({tag, " stall_t3"}, stall_a, 0);
    check({tag, " bus_err_t3"}, err_a, 0);
    if (!st) begin
      check({tag, " wb_rd_data"}, data_a, exp_rd);
      check({tag, " wb_rd_idx"}, idx_a, 9);
    end
    tick();
    check({tag, " wb_valid_t4"}, wbv_a, 0);
  endtask

  initial begin
    rstn = 1'b1;
    idle_inputs();
    bus_a.d_req_ready = 1'b0; bus_a.d_rsp_valid = 1'b0; bus_a.d_rsp_rdata = '0; bus_a.d_rsp_err = 1'b0;
    bus_b.d_req_ready = 1'b0; bus_b.d_rsp_valid = 1'b0; bus_b.d_rsp_rdata = '0; bus_b.d_rsp_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check("reset stall", stall_a, 0);
    check("reset wb_valid", wbv_a, 0);
    check("reset wb_rd_en", wbe_a, 0);
    check("reset misalign", mis_a, 0);
    check("reset bus_err", err_a, 0);
    check("reset req_valid", bus_a.d_req_valid, 0);
    check("reset req_addr", bus_a.d_req_addr, 0);
    check("reset req_wstrb", bus_a.d_req_wstrb, 0);
    check("reset fault_addr", fa_a, 0);
    check("reset wb_rd_data", data_a, 0);

    // Pass-through: one cycle latency, never stalls.
    mv_a = 1'b1; result = 32'h1234_5678; rd = 5'd5; rd_en = 1'b1;
    #1;
    check("pass stall_t0", stall_a, 0);
    tick();
    idle_inputs();
    #1;
    check("pass wb_valid", wbv_a, 1);
    check("pass wb_rd_en", wbe_a, 1);
    check("pass wb_rd_idx", idx_a, 5);
    check("pass wb_rd_data", data_a, 32'h1234_5678);
    check("pass stall_t1", stall_a, 0);
    tick();
    check("pass wb_valid_t2", wbv_a, 0);

    //      tag    st    f3      addr          wdata          rdata          strb     exp_wdata      exp_rd         en
    run_min("lb",  1'b0, 3'b000, 32'h0000_1003, 32'h0,         32'h80AB_CDEF, 4'b0000, 32'h0,         32'hFFFF_FF80, 1'b1);
    run_min("lbu", 1'b0, 3'b100, 32'h0000_1003, 32'h0,         32'h80AB_CDEF, 4'b0000, 32'h0,         32'h0000_0080, 1'b1);
    run_min("lhu", 1'b0, 3'b101, 32'h0000_1002, 32'h0,         32'h80AB_CDEF, 4'b0000, 32'h0,         32'h0000_80AB, 1'b1);
    run_min("lh",  1'b0, 3'b001, 32'h0000_1002, 32'h0,         32'h80AB_CDEF, 4'b0000, 32'h0,         32'hFFFF_80AB, 1'b1);
    run_min("lb1", 1'b0, 3'b000, 32'h0000_1001, 32'h0,         32'h80AB_CDEF, 4'b0000, 32'h0,         32'hFFFF_FFCD, 1'b1);
    run_min("lw",  1'b0, 3'b010, 32'h0000_1000, 32'h0,         32'h80AB_CDEF, 4'b0000, 32'h0,         32'h80AB_CDEF, 1'b1);
    run_min("sb",  1'b1, 3'b000, 32'h0000_1001, 32'h1234_56A5, 32'h0,         4'b0010, 32'hA5A5_A5A5, 32'h0,         1'b0);
    run_min("sw",  1'b1, 3'b010, 32'h0000_1004, 32'hCAFE_F00D, 32'h0,         4'b1111, 32'hCAFE_F00D, 32'h0,         1'b0);

    // SH with three ready-low cycles: fields held, three extra stall cycles.
    stalls = 0;
    mv_a = 1'b1;
    drive_access(1'b1, 3'b001, 32'h0000_2002, 32'hDEAD_BEEF, 5'd2);
    #1;
    stalls += int'(stall_a);
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus_a.d_req_ready = 1'b1;
      #1;
      check("sh req_valid", bus_a.d_req_valid, 1);
      check("sh req_wstrb", bus_a.d_req_wstrb, 4'b1100);
      check("sh req_wdata", bus_a.d_req_wdata, 32'hBEEF_BEEF);
      check("sh req_addr", bus_a.d_req_addr, 32'h0000_2000);
      stalls += int'(stall_a);
      tick();
    end
    bus_a.d_req_ready = 1'b0;
    bus_a.d_rsp_valid = 1'b1;
    #1;
    stalls += int'(stall_a);
    tick();
    bus_a.d_rsp_valid = 1'b0;
    idle_inputs();
    #1;
    check("sh stall_cycles", 32'(stalls), 6);
    check("sh wb_valid", wbv_a, 1);
    check("sh wb_rd_en", wbe_a, 0);
    check("sh stall_done", stall_a, 0);
    tick();

    // Misaligned LW: no request, no stall, one-cycle trap.
    mv_a = 1'b1;
    drive_access(1'b0, 3'b010, 32'h0000_3001, 32'h0, 5'd6);
    #1;
    check("mis stall", stall_a, 0);
    check("mis req_valid", bus_a.d_req_valid, 0);
    tick();
    idle_inputs();
    #1;
    check("mis trap", mis_a, 1);
    check("mis fault_addr", fa_a, 32'h0000_3001);
    check("mis wb_valid", wbv_a, 1);
    check("mis wb_rd_en", wbe_a, 0);
    check("mis req_valid_t1", bus_a.d_req_valid, 0);
    tick();
    check("mis trap_t2", mis_a, 0);

    // TIMEOUT=4, ready never rises: abort after four REQ cycles, late response ignored.
    mv_b = 1'b1;
    drive_access(1'b0, 3'b010, 32'h0000_4000, 32'h0, 5'd3);
    #1;
    check("to stall_t0", stall_b, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("to req_valid", bus_b.d_req_valid, 1);
      check("to bus_err_wait", err_b, 0);
      tick();
    end
    idle_inputs();
    #1;
    check("to bus_err", err_b, 1);
    check("to wb_valid", wbv_b, 1);
    check("to wb_rd_en", wbe_b, 0);
    check("to fault_addr", fa_b, 32'h0000_4000);
    check("to req_valid_drop", bus_b.d_req_valid, 0);
    check("to stall_done", stall_b, 0);
    bus_b.d_rsp_valid = 1'b1;
    bus_b.d_rsp_rdata = 32'hFFFF_FFFF;
    tick();
    check("to late bus_err", err_b, 0);
    check("to late wb_valid", wbv_b, 0);
    tick();
    bus_b.d_rsp_valid = 1'b0;
    check("to late wb_valid2", wbv_b, 0);
    check("to late stall", stall_b, 0);

    // Error response on a load.
    mv_b = 1'b1;
    drive_access(1'b0, 3'b010, 32'h0000_5004, 32'h0, 5'd8);
    bus_b.d_req_ready = 1'b1;
    tick();
    tick();
    bus_b.d_req_ready = 1'b0;
    bus_b.d_rsp_valid = 1'b1;
    bus_b.d_rsp_err = 1'b1;
    tick();
    bus_b.d_rsp_valid = 1'b0;
    bus_b.d_rsp_err = 1'b0;
    idle_inputs();
    #1;
    check("err bus_err", err_b, 1);
    check("err wb_valid", wbv_b, 1);
    check("err wb_rd_en", wbe_b, 0);
    check("err fault_addr", fa_b, 32'h0000_5004);
    tick();
    check("err bus_err_t4", err_b, 0);

    // Response arrives on the limit cycle: response wins.
    mv_b = 1'b1;
    drive_access(1'b0, 3'b010, 32'h0000_5008, 32'h0, 5'd10);
    bus_b.d_req_ready = 1'b1;
    tick();
    tick();
    bus_b.d_req_ready = 1'b0;
    tick();
    tick();
    bus_b.d_rsp_valid = 1'b1;
    bus_b.d_rsp_rdata = 32'h1122_3344;
    tick();
    bus_b.d_rsp_valid = 1'b0;
    idle_inputs();
    #1;
    check("edge wb_valid", wbv_b, 1);
    check("edge wb_rd_en", wbe_b, 1);
    check("edge wb_rd_data", data_b, 32'h1122_3344);
    check("edge bus_err", err_b, 0);
    tick();

    // Reset while waiting for the response.
    mv_a = 1'b1;
    drive_access(1'b0, 3'b010, 32'h0000_6000, 32'h0, 5'd4);
    bus_a.d_req_ready = 1'b1;
    tick();
    tick();
    bus_a.d_req_ready = 1'b0;
    rstn = 1'b1;
    tick();
    rstn = 1'b0;
    idle_inputs();
    bus_a.d_rsp_valid = 1'b1;
    bus_a.d_rsp_rdata = 32'hFFFF_FFFF;
    #1;
    check("rst req_valid", bus_a.d_req_valid, 0);
    check("rst wb_valid", wbv_a, 0);
    check("rst bus_err", err_a, 0);
    check("rst stall", stall_a, 0);
    check("rst req_addr", bus_a.d_req_addr, 0);
    check("rst fault_addr", fa_a, 0);
    tick();
    bus_a.d_rsp_valid = 1'b0;
    check("rst late wb_valid", wbv_a, 0);
    check("rst late wb_rd_en", wbe_a, 0);
    check("rst late wb_rd_data", data_a, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
